// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding, address-field widths and line layout for dcache
package cache_pkg;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

   function automatic int word_bits(input int line_words);
      return (line_words > 1) ? $clog2(line_words) : 0;
   endfunction

   function automatic int index_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_bits(input int addr_width, input int sets, input int line_words);
      return addr_width - 2 - word_bits(line_words) - index_bits(sets);
   endfunction

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_SETS       = 8;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_TAG_W      = tag_bits(DEF_ADDR_WIDTH, DEF_SETS, DEF_LINE_WORDS);

   // Packed view of one line in the default geometry.
   typedef struct packed {
      logic                                valid;
      logic [DEF_TAG_W-1:0]                tag;
      logic [DEF_LINE_WORDS-1:0][31:0]     words;
   } line_t;

endpackage

// File: rtl/dcache_store.sv
// rtl/dcache_store.sv - tag/valid/data arrays: combinational read by index, clocked word/tag writes
module dcache_store
   import cache_pkg::*;
#(
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4,
   parameter int TAG_W      = 25,
   localparam int IB        = index_bits(SETS),
   localparam int FW        = IB + word_bits(LINE_WORDS)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_all,
   input  logic [IB-1:0]    idx,
   input  logic [FW-1:0]    rd_faddr,
   output logic             line_valid,
   output logic [TAG_W-1:0] line_tag,
   output logic [31:0]      line_word,
   input  logic             vld_clr,
   input  logic             tag_we,
   input  logic [TAG_W-1:0] tag_wdata,
   input  logic             word_we,
   input  logic [FW-1:0]    wr_faddr,
   input  logic [31:0]      word_wdata
);

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags  [SETS];
   logic [31:0]      words [SETS*LINE_WORDS];

   assign line_valid = valid[idx];
   assign line_tag   = tags[idx];
   assign line_word  = words[rd_faddr];

   // Miss-time clear and fill-completion set never occur in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_all) begin
         valid <= '0;
      end else begin
         if (vld_clr)
            valid[idx] <= 1'b0;
         if (tag_we)
            valid[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we)
         tags[idx] <= tag_wdata;
      if (word_we)
         words[wr_faddr] <= word_wdata;
   end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-through, no-write-allocate data cache with line refill
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int WB = word_bits(LINE_WORDS);
   localparam int IB = index_bits(SETS);
   localparam int TB = tag_bits(ADDR_WIDTH, SETS, LINE_WORDS);
   localparam int CW = (WB > 0) ? WB : 1;
   localparam int FW = IB + WB;
   localparam logic [ADDR_WIDTH-3:0] WORD_MASK = (ADDR_WIDTH-2)'(LINE_WORDS - 1);

   state_t                  state;
   logic [ADDR_WIDTH-1:2]   lat_addr;
   logic [ADDR_WIDTH-1:2]   rd_addr;
   logic                    lat_we;
   logic [CW-1:0]           cnt;
   logic                    cnt_last;
   logic [IB-1:0]           rd_idx;
   logic [TB-1:0]           rd_tag;
   logic [FW-1:0]           rd_faddr;
   logic [FW-1:0]           fill_faddr;
   logic                    line_valid;
   logic [TB-1:0]           line_tag;
   logic [31:0]             line_word;
   logic                    hit;
   logic                    idle_flush;
   logic                    idle_go;
   logic                    rd_hit_idle;
   logic                    miss_go;
   logic                    wr_go;
   logic                    ack;
   logic                    fill_ack;
   logic                    wr_ack;
   logic                    unused_ok;

   assign unused_ok = ^cpu_addr[1:0];

   // The CPU holds its address, so the latched copy only matters once IDLE is left.
   assign rd_addr = (state == IDLE) ? cpu_addr[ADDR_WIDTH-1:2] : lat_addr;
   assign rd_idx  = rd_addr[2+WB +: IB];
   assign rd_tag  = rd_addr[ADDR_WIDTH-1 -: TB];

   generate
      if (WB > 0) begin : g_word
         assign rd_faddr   = {rd_idx, rd_addr[2 +: WB]};
         assign fill_faddr = {rd_idx, cnt};
      end else begin : g_noword
         assign rd_faddr   = rd_idx;
         assign fill_faddr = rd_idx;
      end
   endgenerate

   assign hit         = line_valid && (line_tag == rd_tag);
   assign idle_flush  = (state == IDLE) && flush;
   assign idle_go     = (state == IDLE) && !flush && cpu_req;
   assign rd_hit_idle = idle_go && !cpu_we && hit;
   assign miss_go     = idle_go && !cpu_we && !hit;
   assign wr_go       = idle_go && cpu_we;
   assign ack         = mem_req && mem_ack;
   assign fill_ack    = (state == FILL) && ack;
   assign wr_ack      = (state == WRITE) && ack;

   assign cpu_ready = rd_hit_idle || (state == RESP);
   assign cpu_rdata = (rd_hit_idle || ((state == RESP) && !lat_we)) ? line_word : '0;

   dcache_store #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TB)
   ) u_store (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_all    (idle_flush),
      .idx        (rd_idx),
      .rd_faddr   (rd_faddr),
      .line_valid (line_valid),
      .line_tag   (line_tag),
      .line_word  (line_word),
      .vld_clr    (miss_go),
      .tag_we     (fill_ack && cnt_last),
      .tag_wdata  (rd_tag),
      .word_we    (fill_ack || (wr_ack && hit)),
      .wr_faddr   (fill_ack ? fill_faddr : rd_faddr),
      .word_wdata (fill_ack ? mem_rdata : mem_wdata)
   );

   generate
      if (WB > 0) begin : g_cnt
         always_ff @(posedge clk) begin
            if (!rst_n || miss_go)
               cnt <= '0;
            else if (fill_ack)
               cnt <= cnt + CW'(1);
         end
         assign cnt_last = (cnt == CW'(LINE_WORDS - 1));
      end else begin : g_nocnt
         assign cnt      = '0;
         assign cnt_last = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_we    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_go) begin
                  lat_addr <= cpu_addr[ADDR_WIDTH-1:2];
                  lat_we   <= 1'b0;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {cpu_addr[ADDR_WIDTH-1:2] & ~WORD_MASK, 2'b00};
                  state    <= FILL;
               end else if (wr_go) begin
                  lat_addr  <= cpu_addr[ADDR_WIDTH-1:2];
                  lat_we    <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata <= cpu_wdata;
                  state     <= WRITE;
               end
            end
            FILL: begin
               if (ack) begin
                  if (cnt_last) begin
                     mem_req <= 1'b0;
                     state   <= RESP;
                  end else begin
                     mem_addr <= mem_addr + ADDR_WIDTH'(4);
                  end
               end
            end
            WRITE: begin
               if (ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= RESP;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (rd_hit_idle && (hit_count != '1))
            hit_count <= hit_count + 32'd1;
         if (miss_go && (miss_count != '1))
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - randomized self-checking bench for dcache against a line-level cache/memory model
module tb_dcache;

   localparam int SETS   = 8;
   localparam int LW     = 4;
   localparam int LBYTES = LW * 4;

   logic        clk = 1'b0;
   logic        rst_n, flush, cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ready, mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   dcache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(SETS), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } txn_t;

   txn_t        txq[$];
   logic [31:0] mem_m [logic [31:0]];
   bit          mv [SETS];
   logic [31:0] mt [SETS];
   logic [31:0] md [SETS][LW];
   int          m_hits, m_misses;
   int          n_cmp = 0, n_bad = 0;
   int          cyc_cnt = 0;
   bit          chk_en;
   int          exp_kind;
   logic [31:0] exp_base;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memval(input logic [31:0] a);
      return mem_m.exists(a) ? mem_m[a] : a;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
      m_hits = 0;
      m_misses = 0;
   endtask

   // Memory: random ack latency, stray acks while idle, junk data on non-ack cycles.
   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && mem_req && ($urandom_range(0, 2) != 0)) begin
            mem_ack = 1'b1;
            mem_rdata = mem_we ? $urandom : memval(mem_addr);
            txq.push_back('{mem_we, mem_addr, mem_wdata, cyc_cnt});
         end else begin
            mem_ack = (!mem_req && $urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // Per-cycle memory-side compare.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && rst_n) begin
            if (exp_kind == 0) begin
               check("mem_req_idle", {31'd0, mem_req}, 32'd0);
            end else if (mem_req) begin
               check("mem_we", {31'd0, mem_we}, {31'd0, exp_kind == 2});
               if (exp_kind == 2) begin
                  check("mem_addr_wr", mem_addr, exp_base);
                  check("mem_wdata", mem_wdata, mem_m.exists(32'hFFFF_FFFC) ? 32'h0 : cpu_wdata);
               end else begin
                  check("mem_addr_fill", mem_addr, exp_base + 32'(4 * txq.size()));
               end
            end
         end
      end
   end

   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output bit was_hit, output logic [31:0] rd);
      int          set, wrd, rdy_cyc, c;
      logic [31:0] tg, base, exp_rd;
      bit          got;
      set  = (a / LBYTES) % SETS;
      wrd  = (a / 4) % LW;
      tg   = a / (LBYTES * SETS);
      base = a - (a % LBYTES);
      was_hit = mv[set] && (mt[set] == tg);
      exp_rd  = was_hit ? md[set][wrd] : memval(a);
      @(negedge clk);
      txq.delete();
      exp_kind = we ? 2 : (was_hit ? 0 : 1);
      exp_base = we ? a : base;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
      got = 0; rd = '0; rdy_cyc = 0; c = 0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (cpu_ready) begin
            got = 1; rd = cpu_rdata; rdy_cyc = cyc_cnt; c = i;
            break;
         end
         @(negedge clk);
      end
      check("ready_timeout", {31'd0, got}, 32'd1);
      if (!we) check("rdata", rd, exp_rd);
      if (exp_kind == 0) begin
         check("hit_latency", c, 0);
         check("hit_mem_txns", txq.size(), 0);
      end else if (exp_kind == 1) begin
         check("fill_beats", txq.size(), LW);
         foreach (txq[k]) begin
            check("fill_txn_we", {31'd0, txq[k].we}, 32'd0);
            check("fill_txn_addr", txq[k].addr, base + 32'(4 * k));
         end
         if (txq.size() > 0) check("fill_resp_cycle", rdy_cyc, txq[$].cyc + 1);
      end else begin
         check("write_txns", txq.size(), 1);
         if (txq.size() > 0) begin
            check("write_txn_addr", txq[0].addr, a);
            check("write_txn_data", txq[0].data, wd);
            check("write_resp_cycle", rdy_cyc, txq[0].cyc + 1);
         end
      end
      if (we) begin
         mem_m[a] = wd;
         if (was_hit) md[set][wrd] = wd;
      end else if (was_hit) begin
         m_hits++;
      end else begin
         m_misses++;
         mv[set] = 1'b1;
         mt[set] = tg;
         for (int k = 0; k < LW; k++) md[set][k] = memval(base + 32'(4 * k));
      end
      @(negedge clk);
      cpu_req = 1'b0;
      exp_kind = 0;
   endtask

   task automatic do_flush(input bit with_req, input logic [31:0] a);
      @(negedge clk);
      flush = 1'b1; cpu_req = with_req; cpu_we = 1'b0; cpu_addr = a;
      #1;
      check("flush_ready", {31'd0, cpu_ready}, 32'd0);
      @(negedge clk);
      flush = 1'b0; cpu_req = 1'b0;
      for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_cpu_ready"}, {31'd0, cpu_ready}, 32'd0);
      check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
      check({tag, "_mem_req"},   {31'd0, mem_req}, 32'd0);
      check({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
      check({tag, "_mem_addr"},  mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   task automatic check_stats();
`ifdef DCACHE_STATS_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit          h;
      logic [31:0] r;
      logic [31:0] a;
      rst_n = 1'b0; flush = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; chk_en = 1'b0; exp_kind = 0; exp_base = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_outputs_zero("reset");
      check_stats();
      chk_en = 1'b1;

      // Cold read, then hit in the same line.
      access(1'b0, 32'h40, 32'h0, h, r);
      check("cold_hit", {31'd0, h}, 32'd0);
      check("cold_rdata", r, 32'h40);
      check("cold_last_beat", (txq.size() == 4) ? txq[3].addr : 32'hX, 32'h4C);
      access(1'b0, 32'h48, 32'h0, h, r);
      check("warm_hit", {31'd0, h}, 32'd1);
      check("warm_rdata", r, 32'h48);

      // Conflict on index 4.
      access(1'b0, 32'h240, 32'h0, h, r);
      check("conflict_hit", {31'd0, h}, 32'd0);
      access(1'b0, 32'h40, 32'h0, h, r);
      check("reload_hit", {31'd0, h}, 32'd0);

      // Write hit updates the line; write miss does not allocate.
      access(1'b1, 32'h44, 32'hDEADBEEF, h, r);
      check("wr_hit_addr", (txq.size() == 1) ? txq[0].addr : 32'hX, 32'h44);
      check("wr_hit_data", (txq.size() == 1) ? txq[0].data : 32'hX, 32'hDEADBEEF);
      access(1'b0, 32'h44, 32'h0, h, r);
      check("wr_hit_readback", r, 32'hDEADBEEF);
      check("wr_hit_readback_hit", {31'd0, h}, 32'd1);
      access(1'b1, 32'h100, 32'h1234, h, r);
      access(1'b0, 32'h100, 32'h0, h, r);
      check("wr_miss_noalloc", {31'd0, h}, 32'd0);
      check("wr_miss_rdata", r, 32'h1234);
      check_stats();

      // Flush beats a simultaneous request.
      do_flush(1'b1, 32'h48);
      access(1'b0, 32'h48, 32'h0, h, r);
      check("post_flush_hit", {31'd0, h}, 32'd0);

      // Reset during the third fill beat.
      do_flush(1'b0, 32'h0);
      @(negedge clk);
      txq.delete();
      exp_kind = 1; exp_base = 32'h40;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (txq.size() >= 2) break;
      end
      check("abort_beats_seen", txq.size(), 2);
      chk_en = 1'b0;
      rst_n = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_outputs_zero("abort");
      model_reset();
      check_stats();
      exp_kind = 0;
      chk_en = 1'b1;
      access(1'b0, 32'h40, 32'h0, h, r);
      check("abort_refill_hit", {31'd0, h}, 32'd0);

      // Random traffic over 4 tags x 8 sets so hits, conflicts and write hits all occur.
      for (int n = 0; n < 300; n++) begin
         a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
         if ($urandom_range(0, 24) == 0)
            do_flush($urandom_range(0, 1) == 1, a);
         else
            access($urandom_range(0, 3) == 0, a, $urandom, h, r);
      end
      check_stats();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, parametrised data cache between the pipeline memory stage and the main data memory. Holds SETS lines of LINE_WORDS words each, with a tag and valid bit per line. Read hits return data in the same cycle as the request. Read misses refill the whole line from memory with a sequential word handshake. Writes are write-through, no-write-allocate. Supersedes the single-word combinational lookup with a clocked, multi-word, miss-handling design.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; fixed at 32 (byte offset is 2 bits)
- SETS, 8, number of lines; power of two, ≥2
- LINE_WORDS, 4, words per line; power of two, ≥1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  invalidate all lines
- cpu_req  in  1  access request; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  word-aligned byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data; valid when cpu_ready && !cpu_we
- cpu_ready  out  1  access complete this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  one word transferred this cycle

## Operation
- Address split: [1:0] byte, then log2(LINE_WORDS) word offset, then log2(SETS) index, then the remaining tag bits.
- Hit = valid[index] && tag[index] == addr tag.
- FSM states: IDLE, FILL, WRITE, RESP.
- IDLE, flush=1: clear all valid bits. flush wins over cpu_req that cycle; cpu_ready=0.
- IDLE, read hit: cpu_ready=1 and cpu_rdata=line word, combinationally. Stay in IDLE.
- IDLE, read miss: clear valid[index], latch the address, word counter := 0, go to FILL.
- IDLE, write: latch address and data, go to WRITE.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, counter, 2'b00}.
  - Each mem_ack writes mem_rdata into line word[counter] and increments counter.
  - The ack on the last word writes tag, sets valid, and goes to RESP.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values.
  - On mem_ack: if hit, update the cached word (no tag or valid change); go to RESP. On a miss, the line is untouched.
- RESP: cpu_ready=1 for exactly one cycle. For reads, cpu_rdata = requested word from the line. Go to IDLE.
- flush outside IDLE is ignored.
- The CPU must hold cpu_addr, cpu_we and cpu_wdata stable while cpu_req=1 and cpu_ready=0.

## Timing
- Reset: state=IDLE, all valid=0, counter=0. cpu_ready, mem_req, mem_we = 0; mem_addr, mem_wdata, cpu_rdata = 0. Tag and data arrays need no reset.
- Reset mid-FILL or mid-WRITE aborts the access. The partially filled set stays invalid.
- Read hit: 0 wait cycles.
- Read miss: LINE_WORDS acks + 1 (RESP) cycles after the acks.
- Write: ack cycle + 1 (RESP).
- mem_req may stay high across consecutive FILL beats; mem_addr advances on the cycle after each ack.
- mem_ack is ignored when mem_req=0. Ack in the same cycle mem_req first rises is legal.
- Counter width is log2(LINE_WORDS). It wraps to 0 after the last beat. With LINE_WORDS=1 the counter is omitted.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count and miss_count (32-bit each). Both saturate at 0xFFFF_FFFF and reset to 0.
  - hit_count increments once per read hit in IDLE.
  - miss_count increments once per IDLE→FILL transition.
  - Writes count in neither.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package cache_pkg holds:
  - the state enum (IDLE, FILL, WRITE, RESP);
  - localparams or functions for offset, index and tag widths;
  - a line struct {valid, tag, words}.
- One sub-module, dcache_store, holds the tag/valid/data arrays:
  - combinational read port by index;
  - clocked word-write port, tag-write port and valid set/clear;
  - global valid clear (for flush and reset).
- dcache holds the FSM, counter, latches and optional stats.

## Test plan
Defaults: SETS=8, LINE_WORDS=4; index = addr[6:4].
- Cold read: reset, read 0x40, memory returns 0x40+n per beat.
  - Expect exactly 4 mem reads at 0x40, 0x44, 0x48, 0x4C, then cpu_ready with rdata=0x40 on the RESP cycle.
  - Then read 0x48: cpu_ready the same cycle, rdata=0x48, mem_req stays 0.
- Conflict: after the cold read, read 0x240 (same index 4) → full 4-beat refill; a following read of 0x40 misses again.
- Write hit: write 0x44 = 0xDEADBEEF → one mem write (0x44, 0xDEADBEEF) and one RESP cycle; a following read of 0x44 hits with 0xDEADBEEF.
- Write miss: write 0x100 = 0x1234 → one mem write, no fill; a following read of 0x100 misses (4 beats).
- Flush: flush in IDLE together with cpu_req → cpu_ready=0 that cycle; a following read of 0x48 misses.
- Reset mid-fill: drop rst_n during the 3rd FILL beat → all outputs 0 next cycle; a following read of 0x40 does a full 4-beat fill. With DCACHE_STATS_EN, check hit_count and miss_count reset to 0 and track the accesses above.
